// File: rtl/loop3_psum_drain.sv
// loop3_psum_drain: captures one 64-lane signed partial-sum block, quantizes
// each lane (ReLU, rounded right shift, unsigned saturation) and drains the
// result downstream as 16-lane beats while freezing the accumulation stage.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no block held; a valid block is captured and quantized
//   DRAIN | hold register being streamed, beat_q selects the current beat;
//         | halt asserted so upstream keeps its next block waiting
module loop3_psum_drain #(
    parameter int LANES      = 64,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int BEAT_LANES = 16,
    parameter int SHIFT      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_v,
    input  logic [LANES*IN_W-1:0]       in_data,
    output logic                        halt,
    output logic                        out_v,
    input  logic                        out_ready,
    output logic [BEAT_LANES*OUT_W-1:0] out_data,
    output logic                        out_last,
    output logic [15:0]                 sat_cnt
);

    localparam int BEATS  = LANES / BEAT_LANES;
    localparam int BEAT_W = BEAT_LANES * OUT_W;
    localparam int HOLD_W = LANES * OUT_W;
    localparam int BIDX_W = $clog2(BEATS);
    localparam int NSAT_W = $clog2(LANES + 1);

    // Rounding constant and clip level, sized to the 17b non-overflowing sum.
    localparam logic [IN_W:0] ROUND = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic [IN_W:0] QMAX  = (IN_W + 1)'((1 << OUT_W) - 1);

    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [BIDX_W-1:0]   beat_q, beat_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [15:0]         sat_cnt_q, sat_cnt_d;

    logic [HOLD_W-1:0]   quant;
    logic [NSAT_W-1:0]   nsat;
    logic [16:0]         sat_sum;

    // Per-lane requantization of the incoming block and count of clipped lanes.
    always_comb begin
        logic [IN_W-1:0] x;
        logic [IN_W:0]   y;
        quant = '0;
        nsat  = '0;
        x     = '0;
        y     = '0;
        for (int i = 0; i < LANES; i++) begin
            x = in_data[i*IN_W +: IN_W];
            y = ({1'b0, x} + ROUND) >> SHIFT;
            if (x[IN_W-1]) begin
                quant[i*OUT_W +: OUT_W] = '0;
            end else if (y > QMAX) begin
                quant[i*OUT_W +: OUT_W] = '1;
                nsat = nsat + NSAT_W'(1);
            end else begin
                quant[i*OUT_W +: OUT_W] = y[OUT_W-1:0];
            end
        end
    end

    // Saturated-lane counter update, clamped at all-ones.
    always_comb begin
        sat_sum = {1'b0, sat_cnt_q} + 17'(nsat);
    end

    // Next-state and output decode; halt depends on state only.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        hold_d    = hold_q;
        sat_cnt_d = sat_cnt_q;
        halt      = 1'b0;
        out_v     = 1'b0;
        out_last  = 1'b0;
        out_data  = hold_q[beat_q*BEAT_W +: BEAT_W];
        case (state_q)
            IDLE: begin
                if (in_v) begin
                    state_d   = DRAIN;
                    beat_d    = '0;
                    hold_d    = quant;
                    sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
                end
            end
            DRAIN: begin
                halt     = 1'b1;
                out_v    = 1'b1;
                out_last = (beat_q == LAST_BEAT);
                if (out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BIDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Control state, beat index and saturation counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            sat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // Quantized block storage; contents are irrelevant outside DRAIN.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_loop3_psum_drain.sv
// Scoreboard bench for loop3_psum_drain: expected beats are queued as blocks
// are issued; a negedge monitor pops and compares on every handshake.
module tb_loop3_psum_drain;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_v;
    logic [1023:0]  in_data;
    logic           halt;
    logic           out_v;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           out_last;
    logic [15:0]    sat_cnt;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } beat_t;

    beat_t sb[$];
    int    nvec = 0;
    int    nerr = 0;
    int    hs   = 0;
    int    exp_sat;

    logic [1023:0] ramp;
    logic [127:0]  ramp_exp[4];

    loop3_psum_drain dut (
        .clk       (clk),
        .rst       (rst),
        .in_v      (in_v),
        .in_data   (in_data),
        .halt      (halt),
        .out_v     (out_v),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_16(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_128(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] fill(input logic [15:0] v);
        return {64{v}};
    endfunction

    task automatic push_blk(input logic [127:0] b0, input logic [127:0] b1,
                            input logic [127:0] b2, input logic [127:0] b3);
        sb.push_back('{data: b0, last: 1'b0});
        sb.push_back('{data: b1, last: 1'b0});
        sb.push_back('{data: b2, last: 1'b0});
        sb.push_back('{data: b3, last: 1'b1});
    endtask

    task automatic push_uniform(input logic [7:0] b);
        push_blk({16{b}}, {16{b}}, {16{b}}, {16{b}});
    endtask

    // Present a block and hold it until the DUT is free to take it; returns
    // #1 after the capturing edge with in_v low again.
    task automatic capture(input logic [1023:0] blk);
        int n = 0;
        in_data = blk;
        in_v    = 1'b1;
        @(negedge clk);
        while (halt && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (halt) begin
            nvec++;
            nerr++;
            $display("FAIL capture_timeout halt stuck at 1");
        end
        @(posedge clk);
        #1;
        in_v = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (halt && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (halt) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout halt stuck at 1");
        end
    endtask

    // Called right after a capture with out_ready=1: beats at T+1..T+4.
    task automatic check_drain_timing(input string tag);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk_b({tag, "_halt"}, halt, 1'b1);
            chk_b({tag, "_out_v"}, out_v, 1'b1);
            chk_b({tag, "_last"}, out_last, c == 4);
        end
        @(negedge clk);
        chk_b({tag, "_halt_fall"}, halt, 1'b0);
        chk_b({tag, "_out_v_fall"}, out_v, 1'b0);
    endtask

    // in_v held high across n blocks; expects a capture every 5 cycles.
    task automatic run_stream(input logic [1023:0] b[3], input int n);
        in_data = b[0];
        in_v    = 1'b1;
        for (int i = 0; i < 5 * n; i++) begin
            @(negedge clk);
            chk_b("stream_halt", halt, (i % 5) != 0);
            chk_b("stream_out_v", out_v, (i % 5) != 0);
            chk_b("stream_last", out_last, (i % 5) == 4);
            @(posedge clk);
            #1;
            if (i % 5 == 0) begin
                if (i / 5 + 1 < n) in_data = b[i / 5 + 1];
                else               in_v    = 1'b0;
            end
        end
        @(negedge clk);
        chk_b("stream_end_halt", halt, 1'b0);
    endtask

    // Monitor: every handshake must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_v && out_ready) begin
                hs++;
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_beat got %h want none", out_data);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk_128("beat_data", out_data, e.data);
                    chk_b("beat_last", out_last, e.last);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1023:0] blk;
        logic [1023:0] sblk[3];
        int            hs0;

        for (int i = 0; i < 64; i++) ramp[i*16 +: 16] = 16'(i * 16);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 16; j++) ramp_exp[k][j*8 +: 8] = 8'(16 * k + j);

        rst       = 1'b1;
        in_v      = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        exp_sat   = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_b("rst_out_v", out_v, 1'b0);
        chk_b("rst_halt", halt, 1'b0);
        chk_b("rst_last", out_last, 1'b0);
        chk_16("rst_sat", sat_cnt, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Quantization of the reference lanes
        blk = '0;
        blk[15:0]  = 16'h0100;
        blk[31:16] = 16'h0FFF;
        blk[47:32] = 16'h8000;
        blk[63:48] = 16'h0017;
        blk[79:64] = 16'h0007;
        push_blk(128'h0100FF10, '0, '0, '0);
        capture(blk);
        check_drain_timing("quant");
        exp_sat = 1;
        chk_16("quant_sat", sat_cnt, 16'(exp_sat));

        // Rounding and clip boundaries, top lane of the last beat
        blk = '0;
        blk[15:0]     = 16'h0FF7;
        blk[31:16]    = 16'h0FF8;
        blk[47:32]    = 16'hFFFF;
        blk[63:48]    = 16'h0008;
        blk[79:64]    = 16'h7FFF;
        blk[1023:1008] = 16'h0ABC;
        push_blk(128'hFF_0100FFFF, '0, '0, {8'hAC, 120'h0});
        @(posedge clk);
        #1;
        capture(blk);
        check_drain_timing("bound");
        exp_sat = 3;
        chk_16("bound_sat", sat_cnt, 16'(exp_sat));

        // Back-pressure at beat 2
        push_blk(ramp_exp[0], ramp_exp[1], ramp_exp[2], ramp_exp[3]);
        hs0 = hs;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        capture(ramp);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_b("bp_out_v", out_v, 1'b1);
            chk_b("bp_halt", halt, 1'b1);
            chk_b("bp_last", out_last, 1'b0);
            chk_128("bp_data", out_data, ramp_exp[2]);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_b("bp_beat3_halt", halt, 1'b1);
        chk_b("bp_beat3_last", out_last, 1'b1);
        @(negedge clk);
        chk_b("bp_halt_fall", halt, 1'b0);
        chk_16("bp_handshakes", 16'(hs - hs0), 16'd4);
        chk_16("bp_sat", sat_cnt, 16'(exp_sat));

        // Halt protocol: second block held on in_v during the first drain
        sblk[0] = fill(16'h0040);
        sblk[1] = fill(16'hF000);
        sblk[2] = '0;
        push_uniform(8'h04);
        push_uniform(8'h00);
        @(posedge clk);
        #1;
        run_stream(sblk, 2);

        // Back-to-back throughput over three blocks
        sblk[0] = fill(16'h0100);
        sblk[1] = fill(16'h0200);
        sblk[2] = fill(16'h0030);
        push_uniform(8'h10);
        push_uniform(8'h20);
        push_uniform(8'h03);
        @(posedge clk);
        #1;
        run_stream(sblk, 3);
        chk_16("stream_sat", sat_cnt, 16'(exp_sat));

        // Reset during beat 1 with the sink stalled
        push_blk(ramp_exp[0], ramp_exp[1], ramp_exp[2], ramp_exp[3]);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        capture(ramp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk_128("rstmid_beat1", out_data, ramp_exp[1]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_sat = 0;
        @(negedge clk);
        chk_b("rstmid_out_v", out_v, 1'b0);
        chk_b("rstmid_halt", halt, 1'b0);
        chk_16("rstmid_sat", sat_cnt, 16'h0000);
        out_ready = 1'b1;
        blk = '0;
        blk[15:0]  = 16'h0100;
        blk[31:16] = 16'h0FFF;
        blk[47:32] = 16'h8000;
        blk[63:48] = 16'h0017;
        blk[79:64] = 16'h0007;
        push_blk(128'h0100FF10, '0, '0, '0);
        @(posedge clk);
        #1;
        capture(blk);
        check_drain_timing("rstmid_new");
        exp_sat = 1;
        chk_16("rstmid_new_sat", sat_cnt, 16'(exp_sat));

        // Saturation counter clamp
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_16("satrun_start", sat_cnt, 16'h0000);
        for (int b = 1; b <= 1100; b++) begin
            push_uniform(8'hFF);
            @(posedge clk);
            #1;
            capture(fill(16'h7FFF));
            wait_idle();
            if (b == 1 || b == 1023 || b == 1024 || b == 1100)
                chk_16("satrun_cnt", sat_cnt, (b * 64 > 65535) ? 16'hFFFF : 16'(b * 64));
        end

        repeat (3) @(negedge clk);
        chk_16("sb_empty", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
